// File: rtl/acc_mem_pkg.sv
// Shared types and default widths for the accumulator processor memory path.
// Used by the memory arbiter and the datapath.
package acc_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; increment has priority over clear
// and holds the count once it reaches LIMIT.
module arb_sat_counter #(
    parameter  int LIMIT = 4,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc) begin
            if (count != W'(LIMIT)) begin
                count <= count + 1'b1;
            end
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Arbitrates the unified instruction/data memory between the CPU datapath and a DMA port.
// Optional performance counters are enabled with the macro ARB_PERF_CNT_EN.
//
// state   | meaning
// CPU_OWN | CPU has priority; DMA wins only when CPU idle or DMA has starved
// DMA_OWN | DMA burst in progress; yields to a waiting CPU after MAX_BURST grants
module acc_mem_arbiter
    import acc_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MAX_BURST  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cpu_stall,
    output logic [31:0]       perf_dma_gnt
`endif
);

    localparam int BURST_W  = $clog2(MAX_BURST + 1);
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    owner_t              rd_tag;
    owner_t              rd_tag_nxt;
    logic [BURST_W-1:0]  burst_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [DATA_W-1:0]   cpu_rdata_q;

    logic cpu_req;
    logic dma_act;
    logic cpu_win;
    logic dma_win;
    logic starve_full;
    logic burst_open;
    logic burst_clr;
    logic starve_inc;
    logic starve_clr;

    // Requests are masked during reset so every combinational output reads zero.
    assign cpu_req     = rst & (cpu_rd | cpu_wr);
    assign dma_act     = rst & dma_req;
    assign starve_full = (starve_cnt == STARVE_W'(STARVE_LIM));
    assign burst_open  = (burst_cnt < BURST_W'(MAX_BURST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CPU_OWN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CPU_OWN: if (dma_win)  state_nxt = DMA_OWN;
            DMA_OWN: if (!dma_win) state_nxt = CPU_OWN;
            default: state_nxt = CPU_OWN;
        endcase
    end

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        case (state)
            CPU_OWN: begin
                cpu_win = cpu_req & ~(dma_act & starve_full);
                dma_win = dma_act & ~cpu_win;
            end
            DMA_OWN: begin
                dma_win = dma_act & (burst_open | ~cpu_req);
                cpu_win = cpu_req & ~dma_win;
            end
            default: begin
                cpu_win = 1'b0;
                dma_win = 1'b0;
            end
        endcase
    end

    assign cpu_stall = cpu_req & ~cpu_win;
    assign dma_gnt   = dma_act & dma_win;

    // burst_cnt is always zero in CPU_OWN, so incrementing on the first DMA win loads 1.
    assign burst_clr  = ~dma_win;
    assign starve_inc = dma_act & ~dma_gnt;
    assign starve_clr = dma_gnt | ~dma_act;

    arb_sat_counter #(
        .LIMIT (MAX_BURST)
    ) u_burst_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dma_win),
        .clr   (burst_clr),
        .count (burst_cnt)
    );

    arb_sat_counter #(
        .LIMIT (STARVE_LIM)
    ) u_starve_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .count (starve_cnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_en    = 1'b1;
            mem_we    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_win) begin
            mem_en    = 1'b1;
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    // A simultaneous cpu_rd/cpu_wr is a write, so it never tags a read return.
    always_comb begin
        rd_tag_nxt = NONE;
        if (cpu_win && !cpu_wr) begin
            rd_tag_nxt = CPU;
        end else if (dma_win && !dma_we) begin
            rd_tag_nxt = DMA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_tag      <= NONE;
            cpu_rdata_q <= '0;
        end else begin
            rd_tag <= rd_tag_nxt;
            if (rd_tag == CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata  = (rd_tag == CPU) ? mem_rdata : cpu_rdata_q;
    assign dma_rvalid = (rd_tag == DMA);
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cpu_stall <= '0;
            perf_dma_gnt   <= '0;
        end else begin
            if (cpu_stall) perf_cpu_stall <= perf_cpu_stall + 32'd1;
            if (dma_gnt)   perf_dma_gnt   <= perf_dma_gnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed bench for acc_mem_arbiter with a write-first synchronous memory model.
module tb_acc_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [11:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [11:0] dma_addr;
    logic [15:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [15:0] dma_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_cpu_stall;
    logic [31:0] perf_dma_gnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:4095];

    acc_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_cpu_stall (perf_cpu_stall),
        .perf_dma_gnt   (perf_dma_gnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic crd, input logic cwr, input logic [11:0] ca,
                         input logic [15:0] cwd, input logic dr, input logic dwe,
                         input logic [11:0] da, input logic [15:0] dwd);
        cpu_rd    = crd;
        cpu_wr    = cwr;
        cpu_addr  = ca;
        cpu_wdata = cwd;
        dma_req   = dr;
        dma_we    = dwe;
        dma_addr  = da;
        dma_wdata = dwd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        mem_rdata = 16'h0000;
        #3;
        checks++;
        if ({cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_we});
        end
        checks++;
        if (cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_rdata got cpu=%h dma=%h exp=0", cpu_rdata, dma_rdata);
        end
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got en=%b stall=%b exp=0", mem_en, cpu_stall);
        end
    endtask

    task automatic test_cpu_read();
        step();
        drive(1'b0, 1'b1, 12'h010, 16'h1234, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 16'h1234 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL cpu_write got en=%b we=%b addr=%h wd=%h stall=%b exp 1 1 010 1234 0",
                     mem_en, mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        step();
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_issue got en=%b we=%b addr=%h stall=%b exp 1 0 010 0",
                     mem_en, mem_we, mem_addr, cpu_stall);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 16'h1234 || dma_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL cpu_read_return got rdata=%h rvalid=%b en=%b exp 1234 0 0", cpu_rdata, dma_rvalid, mem_en);
        end
        step();
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL cpu_rdata_hold got=%h exp=1234", cpu_rdata);
        end
    endtask

    task automatic test_dma_only();
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h100, 16'hAAAA);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h100 || mem_wdata !== 16'hAAAA) begin
            failures++;
            $display("FAIL dma_wr0 got gnt=%b we=%b addr=%h wd=%h exp 1 1 100 aaaa", dma_gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h101, 16'hBBBB);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || mem_addr !== 12'h101 || mem_wdata !== 16'hBBBB) begin
            failures++;
            $display("FAIL dma_wr1 got gnt=%b addr=%h wd=%h exp 1 101 bbbb", dma_gnt, mem_addr, mem_wdata);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h101, 16'h0000);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || mem_we !== 1'b0 || dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dma_rd_issue got gnt=%b we=%b rvalid=%b exp 1 0 0", dma_gnt, mem_we, dma_rvalid);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBBBB || cpu_rdata !== 16'h1234) begin
            failures++;
            $display("FAIL dma_rd_return got rvalid=%b rdata=%h cpu_rdata=%h exp 1 bbbb 1234", dma_rvalid, dma_rdata, cpu_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dma_rvalid_pulse got=%b exp=0", dma_rvalid);
        end
    endtask

    task automatic test_starvation();
        for (int i = 1; i <= 8; i++) begin
            step();
            drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h100, 16'h0000);
            @(negedge clk);
            checks++;
            if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_addr !== 12'h010) begin
                failures++;
                $display("FAIL starve_cpu_win cycle=%0d got gnt=%b stall=%b addr=%h exp 0 0 010", i, dma_gnt, cpu_stall, mem_addr);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 12'h100) begin
            failures++;
            $display("FAIL starve_dma_win got gnt=%b stall=%b addr=%h exp 1 1 100", dma_gnt, cpu_stall, mem_addr);
        end
        step();
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_addr !== 12'h010 || dma_rvalid !== 1'b1 || dma_rdata !== 16'hAAAA) begin
            failures++;
            $display("FAIL starve_cpu_back got stall=%b addr=%h rvalid=%b rdata=%h exp 0 010 1 aaaa",
                     cpu_stall, mem_addr, dma_rvalid, dma_rdata);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 16'h1234 || dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL starve_cpu_rdata got rdata=%h rvalid=%b exp 1234 0", cpu_rdata, dma_rvalid);
        end
    endtask

    task automatic test_burst_limit();
        int gnt_seen;
        int stall_seen;
        gnt_seen   = 0;
        stall_seen = 0;
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b1, 12'h200, 16'h0001);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL burst_first got gnt=%b stall=%b exp 1 0", dma_gnt, cpu_stall);
        end
        if (dma_gnt === 1'b1) gnt_seen++;
        for (int i = 2; i <= 5; i++) begin
            step();
            drive(1'b0, 1'b1, 12'h020, 16'h5A5A, 1'b1, 1'b1, 12'(12'h200 + i - 1), 16'(i));
            @(negedge clk);
            if (dma_gnt === 1'b1) gnt_seen++;
            if (cpu_stall === 1'b1) stall_seen++;
        end
        checks++;
        if (dma_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 12'h020 || mem_wdata !== 16'h5A5A) begin
            failures++;
            $display("FAIL burst_cpu_write got gnt=%b we=%b addr=%h wd=%h exp 0 1 020 5a5a", dma_gnt, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (gnt_seen !== 4) begin
            failures++;
            $display("FAIL burst_grant_count got=%0d exp=4", gnt_seen);
        end
        checks++;
        if (stall_seen !== 3) begin
            failures++;
            $display("FAIL burst_stall_count got=%0d exp=3", stall_seen);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL burst_idle got en=%b exp=0", mem_en);
        end
    endtask

    task automatic test_rd_wr_both();
        step();
        drive(1'b1, 1'b1, 12'h030, 16'h7777, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h030 || mem_wdata !== 16'h7777) begin
            failures++;
            $display("FAIL both_is_write got en=%b we=%b addr=%h wd=%h exp 1 1 030 7777", mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (cpu_rdata !== 16'h1234 || dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL both_no_route got rdata=%h rvalid=%b exp 1234 0", cpu_rdata, dma_rvalid);
        end
    endtask

    task automatic test_reset_mid_read();
        step();
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 12'h101, 16'h0000);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_grant got=%b exp=1", dma_gnt);
        end
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 12'h010, 16'h0000, 1'b1, 1'b0, 12'h101, 16'h0000);
        #1;
        checks++;
        if ({dma_rvalid, dma_gnt, cpu_stall, mem_en, mem_we} !== 5'b0 || dma_rdata !== 16'h0 || cpu_rdata !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got ctrl=%b drd=%h crd=%h exp 00000 0 0",
                     {dma_rvalid, dma_gnt, cpu_stall, mem_en, mem_we}, dma_rdata, cpu_rdata);
        end
        checks++;
        if (mem_addr !== 12'h0 || mem_wdata !== 16'h0) begin
            failures++;
            $display("FAIL rst_mid_mem got addr=%h wd=%h exp 0 0", mem_addr, mem_wdata);
        end
`ifdef ARB_PERF_CNT_EN
        checks++;
        if (perf_cpu_stall !== 32'd0 || perf_dma_gnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got stall=%0d gnt=%0d exp 0 0", perf_cpu_stall, perf_dma_gnt);
        end
`endif
        step();
        checks++;
        if (dma_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_held got rvalid=%b en=%b exp 0 0", dma_rvalid, mem_en);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0 || cpu_rdata !== 16'h0) begin
            failures++;
            $display("FAIL rst_discard got rvalid=%b crd=%h exp 0 0", dma_rvalid, cpu_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_only();
        test_starvation();
        test_burst_limit();
        test_rd_wr_both();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
